// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: operation modes and the
// shift-counter state encoding.
package univ_shift_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'd0,
    MODE_LOAD   = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_SHL    = 3'd3,
    MODE_SHR    = 3'd4,
    MODE_ROTL   = 3'd5,
    MODE_ROTR   = 3'd6,
    MODE_CLEAR  = 3'd7
  } mode_e;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg; the parity output exists only when
// UNIV_SHIFT_REG_PARITY_EN is defined.
interface univ_shift_reg_if
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] t;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CNT_W-1:0] shift_cnt;
  logic             word_done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic             parity;
`endif

  modport master (
    output en, mode, d, t, sin,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    input  parity,
`endif
    input  q, sout, shift_cnt, word_done
  );

  modport slave (
    input  en, mode, d, t, sin,
`ifdef UNIV_SHIFT_REG_PARITY_EN
    output parity,
`endif
    output q, sout, shift_cnt, word_done
  );

endinterface

// File: rtl/univ_shift_reg_shift_word_counter.sv
// Saturating shift counter: counts shifts up to WIDTH, pulses word_done once
// on reaching WIDTH, restarts on clear.
module shift_word_counter
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_word_done
);

  cnt_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Clear wins over inc; in FULL the count is saturated and inc is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (i_clear) begin
      w_state_nxt = ST_FILL;
      w_cnt_nxt   = '0;
    end else if (i_inc) begin
      case (r_state)
        ST_FILL: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_state_nxt = ST_FULL;
            w_done_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt       = r_cnt;
  assign o_word_done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal register: hold/load/toggle/shift/rotate/clear with a
// saturating shift counter. Optional parity output: UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  univ_shift_reg_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_sout, w_sout_nxt;
  logic             w_is_shift;
  logic             w_restart;
  logic [CNT_W-1:0] w_cnt;
  logic             w_word_done;

  assign w_is_shift = bus.en && (bus.mode inside {MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR});
  assign w_restart  = bus.en && (bus.mode inside {MODE_LOAD, MODE_CLEAR});

  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    if (bus.en) begin
      case (bus.mode)
        MODE_LOAD:   w_q_nxt = bus.d;
        MODE_TOGGLE: w_q_nxt = r_q ^ bus.t;
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], bus.sin};
          w_sout_nxt = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_nxt    = {bus.sin, r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        MODE_ROTL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_nxt = r_q[WIDTH-1];
        end
        MODE_ROTR: begin
          w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        MODE_CLEAR:  w_q_nxt = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= '0;
      r_sout <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  // Parity is computed from the next q so it never lags the register.
  logic r_parity;
  always_ff @(posedge clk) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= ^w_q_nxt;
  end
  assign bus.parity = r_parity;
`endif

  shift_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_restart),
    .i_inc       (w_is_shift),
    .o_cnt       (w_cnt),
    .o_word_done (w_word_done)
  );

  assign bus.q         = r_q;
  assign bus.sout      = r_sout;
  assign bus.shift_cnt = w_cnt;
  assign bus.word_done = w_word_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed vector table, then random
// traffic against a behavioural model.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       en;
    mode_e      mode;
    logic [7:0] d;
    logic [7:0] t;
    logic       sin;
    logic [7:0] eq;
    logic       esout;
    logic [3:0] ecnt;
    logic       edone;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // behavioural model state
  logic [7:0] m_q;
  logic       m_sout;
  int         m_cnt;
  logic       m_done;

  task automatic drive(input logic rst, input logic en, input mode_e mode,
                       input logic [7:0] d, input logic [7:0] t, input logic sin);
    reset    = rst;
    bus.en   = en;
    bus.mode = mode;
    bus.d    = d;
    bus.t    = t;
    bus.sin  = sin;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] eq, input logic esout,
                           input logic [3:0] ecnt, input logic edone);
    n_vec++;
    chk("q", idx, bus.q, eq);
    chk("sout", idx, 8'(bus.sout), 8'(esout));
    chk("shift_cnt", idx, 8'(bus.shift_cnt), 8'(ecnt));
    chk("word_done", idx, 8'(bus.word_done), 8'(edone));
`ifdef UNIV_SHIFT_REG_PARITY_EN
    chk("parity", idx, 8'(bus.parity), 8'(^eq));
`endif
  endtask

  // Reference: plain arithmetic on the architectural state.
  task automatic model_step(input logic rst, input logic en, input mode_e mode,
                            input logic [7:0] d, input logic [7:0] t, input logic sin);
    bit shifted;
    shifted = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      m_q = 0; m_sout = 0; m_cnt = 0;
    end else if (en) begin
      case (int'(mode))
        1: begin m_q = d; m_cnt = 0; end
        2: m_q = m_q ^ t;
        3: begin m_sout = m_q[7]; m_q = 8'((m_q * 2) + sin); shifted = 1; end
        4: begin m_sout = m_q[0]; m_q = 8'((m_q / 2) + (sin ? 128 : 0)); shifted = 1; end
        5: begin m_sout = m_q[7]; m_q = 8'((m_q * 2) + (m_q / 128)); shifted = 1; end
        6: begin m_sout = m_q[0]; m_q = 8'((m_q / 2) + ((m_q % 2) * 128)); shifted = 1; end
        7: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
      if (shifted && m_cnt < W) begin
        m_cnt++;
        m_done = (m_cnt == W);
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    drive(1'b1, 1'b1, MODE_LOAD, 8'hFF, 8'h00, 1'b0);

    //              rst en mode         d      t      sin  q      so cnt done
    tbl.push_back('{1, 1, MODE_LOAD,   8'hFF, 8'h00, 0,   8'h00, 0, 0, 0});
    tbl.push_back('{1, 1, MODE_LOAD,   8'hFF, 8'h00, 0,   8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'hA5, 8'h00, 0,   8'hA5, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_TOGGLE, 8'h00, 8'h0F, 0,   8'hAA, 0, 0, 0});
    tbl.push_back('{0, 0, MODE_CLEAR,  8'h00, 8'h00, 0,   8'hAA, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'hB4, 8'h00, 0,   8'hB4, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h68, 1, 1, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'hD0, 0, 2, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'hA0, 1, 3, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h40, 1, 4, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h80, 0, 5, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h00, 1, 6, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h00, 0, 7, 0});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h00, 0, 8, 1});
    tbl.push_back('{0, 1, MODE_SHL,    8'h00, 8'h00, 0,   8'h00, 0, 8, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'h81, 8'h00, 0,   8'h81, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_ROTR,   8'h00, 8'h00, 0,   8'hC0, 1, 1, 0});
    tbl.push_back('{0, 1, MODE_ROTL,   8'h00, 8'h00, 0,   8'h81, 1, 2, 0});
    tbl.push_back('{0, 1, MODE_ROTL,   8'h00, 8'h00, 0,   8'h03, 1, 3, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'h00, 8'h00, 0,   8'h00, 1, 0, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'h80, 0, 1, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'hC0, 0, 2, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'hE0, 0, 3, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'hF0, 0, 4, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'hF8, 0, 5, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'h3C, 8'h00, 0,   8'h3C, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 0,   8'h1E, 0, 1, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 0,   8'h0F, 0, 2, 0});
    tbl.push_back('{0, 1, MODE_SHR,    8'h00, 8'h00, 0,   8'h07, 1, 3, 0});
    tbl.push_back('{1, 1, MODE_SHR,    8'h00, 8'h00, 1,   8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_LOAD,   8'h07, 8'h00, 0,   8'h07, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_TOGGLE, 8'h00, 8'h01, 0,   8'h06, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_HOLD,   8'hFF, 8'hFF, 1,   8'h06, 0, 0, 0});
    tbl.push_back('{0, 1, MODE_CLEAR,  8'hFF, 8'hFF, 1,   8'h00, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].t, tbl[i].sin);
      @(posedge clk);
      #1;
      check_all(i, tbl[i].eq, tbl[i].esout, tbl[i].ecnt, tbl[i].edone);
    end

    // Hand-written corner: en=0 during the completing shift suppresses the pulse,
    // and the pulse appears only when the eighth enabled shift lands.
    drive(1'b0, 1'b1, MODE_LOAD, 8'hFF, 8'h00, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, MODE_ROTL, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, MODE_ROTL, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check_all(1000, 8'hFF, 1'b1, 4'd7, 1'b0);
    drive(1'b0, 1'b1, MODE_ROTL, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check_all(1001, 8'hFF, 1'b1, 4'd8, 1'b1);
    drive(1'b0, 1'b1, MODE_TOGGLE, 8'h00, 8'hF0, 1'b0);
    @(posedge clk); #1;
    check_all(1002, 8'h0F, 1'b1, 4'd8, 1'b0);

    // Random phase: start the model from a reset cycle.
    model_step(1'b1, 1'b0, MODE_HOLD, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, MODE_HOLD, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check_all(2000, m_q, m_sout, 4'(m_cnt), m_done);
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_en, r_sin;
      mode_e      r_mode;
      logic [7:0] r_d, r_t;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_en   = ($urandom_range(0, 7) != 0);
      // Bias toward shifts so the counter regularly reaches FULL.
      r_mode = ($urandom_range(0, 3) != 0) ? mode_e'($urandom_range(3, 6))
                                           : mode_e'($urandom_range(0, 7));
      r_d    = 8'($urandom);
      r_t    = 8'($urandom);
      r_sin  = 1'($urandom);
      drive(r_rst, r_en, r_mode, r_d, r_t, r_sin);
      model_step(r_rst, r_en, r_mode, r_d, r_t, r_sin);
      @(posedge clk); #1;
      check_all(3000 + i, m_q, m_sout, 4'(m_cnt), m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
